// File: rtl/alu_cmd_engine.sv
// ---------------------------------------------------------------------------
// alu_cmd_engine
//
// Single-issue command engine in front of the 8-bit / 4-bit-opcode ALU
// function set. It accepts one 16-bit instruction at a time and reads both
// operands from an internal register file. It evaluates the op, writes the
// result back to rd, and returns result, carry and rd on a response channel.
//
// Instruction word:
//   [15:12] ctrl (opcode)   [11:9] rd   [8:6] rs1   [5:3] rs2   [2:0] reserved
//   ctrl = 4'hF (LOADI): [7:0] is the immediate written to rd.
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   synchronous, active-high
//   in_valid   in   instruction valid
//   in_ready   out  engine idle and able to accept an instruction
//   in_inst    in   16-bit instruction word
//   out_valid  out  response valid (held until out_ready)
//   out_ready  in   consumer accepts the response
//   out_data   out  result written to rd
//   out_carry  out  carry (ADD) / borrow (SUB), 0 for all other ops
//   out_rd     out  destination register index of the result
//   busy       out  high whenever the engine is not IDLE
//   out_zero   out  result == 0 (only when ALU_ZERO_FLAG_EN is defined)
//
// Build option: define ALU_ZERO_FLAG_EN to add the out_zero flag.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module alu_cmd_engine #(
   parameter int DW   = 8,
   parameter int NREG = 8   // index width is fixed at 3 bits
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [15:0]   in_inst,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          out_carry,
   output logic [2:0]    out_rd,
   output logic          busy
`ifdef ALU_ZERO_FLAG_EN
   ,
   output logic          out_zero
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      EXEC,
      RESP
   } state_e;

   typedef enum logic [3:0] {
      OP_ADD   = 4'd0,
      OP_SUB   = 4'd1,
      OP_AND   = 4'd2,
      OP_OR    = 4'd3,
      OP_NOT   = 4'd4,
      OP_XOR   = 4'd5,
      OP_NOR   = 4'd6,
      OP_SLL   = 4'd7,
      OP_SRL   = 4'd8,
      OP_SRA   = 4'd9,
      OP_RL    = 4'd10,
      OP_RR    = 4'd11,
      OP_EQ    = 4'd12,
      OP_LOADI = 4'd15
   } op_e;

   state_e        state_q, state_d;
   logic [15:0]   inst_q;
   logic [DW-1:0] op_a_q, op_b_q;
   logic [DW-1:0] rf_q [NREG];
   logic [DW-1:0] out_data_q;
   logic          out_carry_q;
   logic [2:0]    out_rd_q;
   logic [DW:0]   alu_res_d;     // {carry, result}
   logic          accept;

   op_e        op;
   logic [2:0] rd_w, rs1_w, rs2_w;

   assign op    = op_e'(inst_q[15:12]);
   assign rd_w  = inst_q[11:9];
   assign rs1_w = inst_q[8:6];
   assign rs2_w = inst_q[5:3];

   // ---------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------
   // NOTE: state is updated with non-blocking assignments so every flop in
   // the design samples its inputs from the same pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------
   // FSM next state and handshake outputs
   // ---------------------------------------------------------------------
   // NOTE: every output of this block gets a default first, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) state_d = READ;
         end
         READ: state_d = EXEC;
         EXEC: state_d = RESP;
         RESP: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign accept = in_valid && in_ready;

   // ---------------------------------------------------------------------
   // ALU: bit DW carries the ADD carry / SUB borrow; every other op
   // leaves it 0 by construction.
   // ---------------------------------------------------------------------
   always_comb begin
      alu_res_d = '0;
      case (op)
         OP_ADD:   alu_res_d = {1'b0, op_a_q} + {1'b0, op_b_q};
         OP_SUB:   alu_res_d = {1'b0, op_a_q} - {1'b0, op_b_q};
         OP_AND:   alu_res_d = {1'b0, op_a_q & op_b_q};
         OP_OR:    alu_res_d = {1'b0, op_a_q | op_b_q};
         OP_NOT:   alu_res_d = {1'b0, ~op_a_q};
         OP_XOR:   alu_res_d = {1'b0, op_a_q ^ op_b_q};
         OP_NOR:   alu_res_d = {1'b0, ~(op_a_q | op_b_q)};
         OP_SLL:   alu_res_d = {1'b0, op_a_q[DW-2:0], 1'b0};
         OP_SRL:   alu_res_d = {2'b00, op_a_q[DW-1:1]};
         OP_SRA:   alu_res_d = {1'b0, op_a_q[DW-1], op_a_q[DW-1:1]};
         OP_RL:    alu_res_d = {1'b0, op_a_q[DW-2:0], op_a_q[DW-1]};
         OP_RR:    alu_res_d = {1'b0, op_a_q[0], op_a_q[DW-1:1]};
         OP_EQ:    alu_res_d = (DW+1)'(op_a_q == op_b_q);
         OP_LOADI: alu_res_d = (DW+1)'(inst_q[7:0]);
         default:  alu_res_d = '0;   // opcodes 13 and 14 return 0
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath: instruction latch, operand fetch, writeback, response regs
   // ---------------------------------------------------------------------
   // NOTE: the register file sits in flops and is cleared by reset, since a
   // read of a never-written register must return 0. A reset in EXEC
   // therefore also discards the pending writeback.
   always_ff @(posedge clk) begin
      if (reset) begin
         inst_q      <= '0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         out_data_q  <= '0;
         out_carry_q <= 1'b0;
         out_rd_q    <= '0;
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else begin
         if (accept) inst_q <= in_inst;
         if (state_q == READ) begin
            // rd == rs is fine: sources are captured here, before EXEC writes
            op_a_q <= rf_q[rs1_w];
            op_b_q <= rf_q[rs2_w];
         end
         if (state_q == EXEC) begin
            rf_q[rd_w]  <= alu_res_d[DW-1:0];
            out_data_q  <= alu_res_d[DW-1:0];
            out_carry_q <= alu_res_d[DW];
            out_rd_q    <= rd_w;
         end
      end
   end

   assign out_data  = out_data_q;
   assign out_carry = out_carry_q;
   assign out_rd    = out_rd_q;

`ifdef ALU_ZERO_FLAG_EN
   // For EQ the result is 0 exactly when x != y, so the flag falls out of the
   // same compare.
   logic out_zero_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         out_zero_q <= 1'b0;
      end else if (state_q == EXEC) begin
         out_zero_q <= (alu_res_d[DW-1:0] == '0);
      end
   end

   assign out_zero = out_zero_q;
`endif

endmodule

// File: tb/tb_alu_cmd_engine.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_engine
//
// Self-checking bench for alu_cmd_engine. A register-file model with
// integer arithmetic predicts every response. Directed scenarios cover reset,
// arithmetic, shifts, backpressure and mid-operation reset, followed by a
// randomized instruction stream with random response backpressure.
// Define ALU_ZERO_FLAG_EN on both files to also check out_zero.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_alu_cmd_engine;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [15:0]   in_inst = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic          out_carry;
   logic [2:0]    out_rd;
   logic          busy;
`ifdef ALU_ZERO_FLAG_EN
   logic          out_zero;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int rf_m [8];

   alu_cmd_engine #(.DW(DW), .NREG(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_inst   (in_inst),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_carry (out_carry),
      .out_rd    (out_rd),
      .busy      (busy)
`ifdef ALU_ZERO_FLAG_EN
      ,
      .out_zero  (out_zero)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [2:0] rs2);
      logic [2:0] rsvd;
      rsvd = 3'($urandom);   // reserved bits must not matter
      return {op, rd, rs1, rs2, rsvd};
   endfunction

   function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [7:0] imm);
      return {4'hF, rd, 1'b0, imm};
   endfunction

   // Reference model: plain integer arithmetic on register values 0..255.
   function automatic void model(input logic [15:0] inst, output int data, output int carry);
      int x, y, s;
      x = rf_m[inst[8:6]];
      y = rf_m[inst[5:3]];
      data  = 0;
      carry = 0;
      case (int'(inst[15:12]))
         0:  begin s = x + y; data = s % 256;         carry = (s > 255) ? 1 : 0; end
         1:  begin s = x - y; data = (s + 256) % 256; carry = (s < 0) ? 1 : 0;   end
         2:  data = x & y;
         3:  data = x | y;
         4:  data = 255 - x;
         5:  data = x ^ y;
         6:  data = 255 - (x | y);
         7:  data = (x * 2) % 256;
         8:  data = x / 2;
         9:  data = x / 2 + ((x >= 128) ? 128 : 0);
         10: data = (x * 2) % 256 + x / 128;
         11: data = x / 2 + (x % 2) * 128;
         12: data = (x == y) ? 1 : 0;
         15: data = int'(inst[7:0]);
         default: data = 0;
      endcase
   endfunction

   // Issues one instruction from IDLE (entered and left at a negedge) and
   // checks latency, response fields, hold stability and return to IDLE.
   task automatic run_inst(input logic [15:0] inst, input int hold,
                           output int got_d, output int got_c);
      int exp_d, exp_c, cyc;
      logic [2:0] exp_rd;
      model(inst, exp_d, exp_c);
      exp_rd   = inst[11:9];
      got_d    = -1;
      got_c    = -1;
      in_valid = 1'b1;
      in_inst  = inst;
      out_ready = (hold == 0);
      cyc = 0;
      while (!in_ready && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      if (!in_ready) begin
         check("accept_timeout", 0, 1);
         in_valid = 1'b0;
         return;
      end
      // cycle 0 is the accepting cycle; the response must appear in cycle 3
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            // noise while busy must be ignored
            in_valid = 1'($urandom_range(0, 1));
            in_inst  = 16'($urandom);
         end
      end while (!out_valid && cyc < 12);
      check("latency", cyc, 3);
      if (!out_valid) begin
         in_valid = 1'b0;
         return;
      end
      got_d = int'(out_data);
      got_c = int'(out_carry);
      check("data", out_data, exp_d);
      check("carry", out_carry, exp_c);
      check("rd", out_rd, exp_rd);
      check("resp_in_ready", in_ready, 0);
      check("resp_busy", busy, 1);
`ifdef ALU_ZERO_FLAG_EN
      check("zero", out_zero, (exp_d == 0));
`endif
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check("hold_valid", out_valid, 1);
         check("hold_data", out_data, exp_d);
         check("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("resp_done", out_valid, 0);
      check("idle_ready", in_ready, 1);
      rf_m[exp_rd] = exp_d;
      in_valid  = 1'b0;
      out_ready = 1'b0;
   endtask

   initial begin
      int d, c, exp_d, exp_c;
      logic [15:0] a, b;
      logic [7:0] shift_exp [5];
      logic [15:0] inst;

      for (int i = 0; i < 8; i++) rf_m[i] = 0;

      // ---- reset held for 2 cycles, then idle ----
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_carry", out_carry, 0);
      check("rst_out_rd", out_rd, 0);

      run_inst(enc(4'd1, 3'd0, 3'd0, 3'd0), 0, d, c);
      check("sub_r0_data", d, 0);
      check("sub_r0_carry", c, 0);

      // ---- LOADI + ADD with carry out ----
      run_inst(ldi(3'd1, 8'hC8), 0, d, c);
      run_inst(ldi(3'd2, 8'h64), 0, d, c);
      run_inst(enc(4'd0, 3'd3, 3'd1, 3'd2), 0, d, c);
      check("add_data", d, 8'h2C);
      check("add_carry", c, 1);

      // ---- SUB borrow both ways ----
      run_inst(ldi(3'd1, 8'h05), 0, d, c);
      run_inst(ldi(3'd2, 8'h07), 0, d, c);
      run_inst(enc(4'd1, 3'd3, 3'd1, 3'd2), 0, d, c);
      check("sub_lo_data", d, 8'hFE);
      check("sub_lo_carry", c, 1);
      run_inst(enc(4'd1, 3'd4, 3'd2, 3'd1), 0, d, c);
      check("sub_hi_data", d, 8'h02);
      check("sub_hi_carry", c, 0);

      // ---- shifts and rotates of 8'h81 ----
      shift_exp[0] = 8'h02;
      shift_exp[1] = 8'h40;
      shift_exp[2] = 8'hC0;
      shift_exp[3] = 8'h03;
      shift_exp[4] = 8'hC0;
      run_inst(ldi(3'd1, 8'h81), 0, d, c);
      for (int k = 0; k < 5; k++) begin
         run_inst(enc(4'(7 + k), 3'd5, 3'd1, 3'd2), 0, d, c);
         check("shift_data", d, shift_exp[k]);
         check("shift_carry", c, 0);
      end

      // ---- EQ with rs1 == rs2 ----
      run_inst(enc(4'd12, 3'd5, 3'd1, 3'd1), 0, d, c);
      check("eq_same", d, 1);

      // ---- backpressure with a pending instruction ----
      a = enc(4'd5, 3'd6, 3'd1, 3'd2);   // XOR r6 = r1 ^ r2
      b = enc(4'd0, 3'd7, 3'd6, 3'd1);   // ADD r7 = r6 + r1 (depends on a)
      model(a, exp_d, exp_c);
      in_valid  = 1'b1;
      in_inst   = a;
      out_ready = 1'b0;
      check("bp_accept_ready", in_ready, 1);
      @(negedge clk);
      in_inst = b;
      @(negedge clk);
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, exp_d);
      for (int h = 0; h < 4; h++) begin
         @(negedge clk);
         check("bp_hold_valid", out_valid, 1);
         check("bp_hold_data", out_data, exp_d);
         check("bp_hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_ready", in_ready, 1);
      check("bp_release_valid", out_valid, 0);
      rf_m[6] = exp_d;
      run_inst(b, 0, d, c);   // still pending: accepted on the next edge

      // ---- reset while ADD r4 = r1 + r2 is in EXEC ----
      in_valid  = 1'b1;
      in_inst   = enc(4'd0, 3'd4, 3'd1, 3'd2);
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check("mid_busy_exec", busy, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("mid_out_valid", out_valid, 0);
      check("mid_in_ready", in_ready, 1);
      check("mid_busy", busy, 0);
      check("mid_out_data", out_data, 0);
      check("mid_out_rd", out_rd, 0);
      for (int i = 0; i < 8; i++) rf_m[i] = 0;
      for (int h = 0; h < 3; h++) begin
         @(negedge clk);
         check("mid_no_pulse", out_valid, 0);
      end
      run_inst(enc(4'd3, 3'd7, 3'd4, 3'd4), 0, d, c);
      check("mid_r4_cleared", d, 0);

      // ---- randomized stream with random backpressure and idle gaps ----
      for (int n = 0; n < 60; n++) begin
         inst = 16'($urandom);
         if ($urandom_range(0, 3) == 0) inst[15:12] = 4'hF;
         run_inst(inst, int'($urandom_range(0, 3)), d, c);
         for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
            @(negedge clk);
            check("gap_in_ready", in_ready, 1);
            check("gap_busy", busy, 0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
